// File: rtl/gpio_pinmux_cfg.sv
// Run-time programmable pad multiplexer: per-pad function select with a tristate guard
// on every function change, sticky per-pad locks, registered pad outputs and input synchroniser.

module gpio_pinmux_cfg #(
    parameter int NUM_PINS     = 24,
    parameter int NUM_FUNCS    = 4,
    parameter int SEL_W        = $clog2(NUM_FUNCS),
    parameter int PIN_W        = $clog2(NUM_PINS),
    parameter int GUARD_CYCLES = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [PIN_W-1:0]              cfg_pin_i,
    input  logic [SEL_W-1:0]              cfg_func_i,
    input  logic                          cfg_lock_i,
    output logic                          cfg_done_o,
    output logic                          cfg_err_o,
    output logic [NUM_PINS*SEL_W-1:0]     sel_o,
    output logic [NUM_PINS-1:0]           lock_o,
    input  logic [NUM_PINS*NUM_FUNCS-1:0] func_o_i,
    input  logic [NUM_PINS*NUM_FUNCS-1:0] func_oe_i,
    input  logic [NUM_PINS-1:0]           pad_i,
    output logic [NUM_PINS-1:0]           pad_o,
    output logic [NUM_PINS-1:0]           pad_oe_o,
    output logic [NUM_PINS-1:0]           pad_sync_o,
    output logic [1:0]                    state_o
);

    localparam int CNT_W = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, GUARD = 2'd1, COMMIT = 2'd2} state_t;

    state_t                         state_q, state_d;
    logic [PIN_W-1:0]               pin_q, pin_d;
    logic [SEL_W-1:0]               func_q, func_d;
    logic                           lock_req_q, lock_req_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [NUM_PINS-1:0][SEL_W-1:0] sel_q, sel_d;
    logic [NUM_PINS-1:0]            guard_q, guard_d;
    logic [NUM_PINS-1:0]            lock_q, lock_d;
    logic                           err_q, err_d;
    logic                           pin_ok, func_ok, req_ok;
    logic [NUM_PINS-1:0]            pad_d, pad_oe_d, pad_q, pad_oe_q;
    logic [NUM_FUNCS-1:0]           fo, foe;
    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q;

    // Range checks collapse to constants when the field width exactly covers the range.
    if (NUM_PINS == (1 << PIN_W)) begin : g_pin_full
        assign pin_ok = 1'b1;
    end else begin : g_pin_part
        assign pin_ok = (32'(cfg_pin_i) < 32'(NUM_PINS));
    end

    if (NUM_FUNCS == (1 << SEL_W)) begin : g_func_full
        assign func_ok = 1'b1;
    end else begin : g_func_part
        assign func_ok = (32'(cfg_func_i) < 32'(NUM_FUNCS));
    end

    assign req_ok = pin_ok && func_ok && !lock_q[cfg_pin_i];

    // Handshake: a request transfers on a rising clk_i edge where cfg_valid_i && cfg_ready_o;
    // cfg_ready_o is high only in IDLE and the requester must hold pin/func/lock until then.
    always_comb begin
        state_d    = state_q;
        pin_d      = pin_q;
        func_d     = func_q;
        lock_req_d = lock_req_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        guard_d    = guard_q;
        lock_d     = lock_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    if (!req_ok) begin
                        err_d = 1'b1;
                    end else begin
                        pin_d      = cfg_pin_i;
                        func_d     = cfg_func_i;
                        lock_req_d = cfg_lock_i;
                        if (cfg_func_i == sel_q[cfg_pin_i]) begin
                            state_d = COMMIT;
                        end else begin
                            guard_d[cfg_pin_i] = 1'b1;
                            cnt_d              = CNT_W'(GUARD_CYCLES - 1);
                            state_d            = GUARD;
                        end
                    end
                end
            end
            GUARD: begin
                if (cnt_q == '0) begin
                    sel_d[pin_q]   = func_q;
                    guard_d[pin_q] = 1'b0;
                    state_d        = COMMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            COMMIT: begin
                if (lock_req_q) lock_d[pin_q] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pads register from the next-cycle select/guard so a change lands in the same
    // cycle as the select update rather than one cycle later.
    always_comb begin
        pad_d    = '0;
        pad_oe_d = '0;
        fo       = '0;
        foe      = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            fo          = func_o_i[p*NUM_FUNCS +: NUM_FUNCS];
            foe         = func_oe_i[p*NUM_FUNCS +: NUM_FUNCS];
            pad_d[p]    = fo[sel_d[p]];
            pad_oe_d[p] = !guard_d[p] && foe[sel_d[p]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pin_q      <= '0;
            func_q     <= '0;
            lock_req_q <= 1'b0;
            cnt_q      <= '0;
            sel_q      <= '0;
            guard_q    <= '0;
            lock_q     <= '0;
            err_q      <= 1'b0;
            pad_q      <= '0;
            pad_oe_q   <= '0;
            sync_q     <= '0;
        end else begin
            state_q    <= state_d;
            pin_q      <= pin_d;
            func_q     <= func_d;
            lock_req_q <= lock_req_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            guard_q    <= guard_d;
            lock_q     <= lock_d;
            err_q      <= err_d;
            pad_q      <= pad_d;
            pad_oe_q   <= pad_oe_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    assign cfg_ready_o = (state_q == IDLE);
    assign cfg_done_o  = (state_q == COMMIT);
    assign cfg_err_o   = err_q;
    assign sel_o       = sel_q;
    assign lock_o      = lock_q;
    assign pad_o       = pad_q;
    assign pad_oe_o    = pad_oe_q;
    assign pad_sync_o  = sync_q[SYNC_STAGES-1];
    assign state_o     = state_q;

endmodule

// File: tb/tb_gpio_pinmux_cfg.sv
// Bench for gpio_pinmux_cfg: scheduled-event reference model plus one task per feature.

module tb_gpio_pinmux_cfg;

    localparam int NP = 24;
    localparam int NF = 4;
    localparam int SW = 2;
    localparam int PW = 5;
    localparam int G  = 2;
    localparam int S  = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic cfg_valid, cfg_lock, cfg_ready, cfg_done, cfg_err;
    logic [PW-1:0] cfg_pin;
    logic [SW-1:0] cfg_func;
    logic [NP*SW-1:0] sel;
    logic [NP-1:0] lock, pad_in, pad_out, pad_oe, pad_sync;
    logic [NP*NF-1:0] func_o, func_oe;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gpio_pinmux_cfg #(.NUM_PINS(NP), .NUM_FUNCS(NF), .GUARD_CYCLES(G), .SYNC_STAGES(S)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_pin_i(cfg_pin), .cfg_func_i(cfg_func), .cfg_lock_i(cfg_lock),
        .cfg_done_o(cfg_done), .cfg_err_o(cfg_err), .sel_o(sel), .lock_o(lock),
        .func_o_i(func_o), .func_oe_i(func_oe), .pad_i(pad_in), .pad_o(pad_out),
        .pad_oe_o(pad_oe), .pad_sync_o(pad_sync), .state_o(dbg_state)
    );

    // Reference model: each accepted request becomes a schedule of edge numbers at which
    // the select, done pulse, lock bit and readiness change.
    int m_sel[NP];
    bit m_lock[NP];
    int edge_n = 0, free_edge = 0, done_edge = -1, lock_edge = -1;
    int g_pin = 0, g_func = 0, g_end = 0;
    bit pend = 1'b0, m_acc = 1'b0;
    logic [NP-1:0] pad_hist[$];
    logic exp_ready, exp_done, exp_err;
    logic [NP*SW-1:0] exp_sel;
    logic [NP-1:0] exp_lock, exp_pad, exp_oe, exp_sync;

    always @(posedge clk) begin
        edge_n++;
        m_acc = 1'b0;
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin m_sel[p] = 0; m_lock[p] = 1'b0; end
            pend = 1'b0; done_edge = -1; lock_edge = -1; free_edge = edge_n + 1;
            pad_hist.delete();
            exp_err = 1'b0; exp_pad = '0; exp_oe = '0;
        end else begin
            exp_err = 1'b0;
            if (pend && edge_n == g_end) begin m_sel[g_pin] = g_func; pend = 1'b0; end
            if (edge_n == lock_edge) m_lock[g_pin] = 1'b1;
            if (cfg_valid && edge_n >= free_edge) begin
                m_acc = 1'b1;
                if (int'(cfg_pin) >= NP || int'(cfg_func) >= NF || m_lock[cfg_pin]) begin
                    exp_err = 1'b1;
                    free_edge = edge_n + 1;
                end else begin
                    g_pin = int'(cfg_pin);
                    g_func = int'(cfg_func);
                    if (g_func == m_sel[g_pin]) begin
                        done_edge = edge_n;
                        lock_edge = cfg_lock ? edge_n + 1 : -1;
                        free_edge = edge_n + 2;
                    end else begin
                        pend = 1'b1;
                        g_end = edge_n + G;
                        done_edge = edge_n + G;
                        lock_edge = cfg_lock ? edge_n + G + 1 : -1;
                        free_edge = edge_n + G + 2;
                    end
                end
            end
            pad_hist.push_back(pad_in);
            if (pad_hist.size() > S) void'(pad_hist.pop_front());
            for (int p = 0; p < NP; p++) begin
                exp_pad[p] = func_o[p*NF + m_sel[p]];
                exp_oe[p]  = (pend && p == g_pin) ? 1'b0 : func_oe[p*NF + m_sel[p]];
            end
        end
        exp_done  = rst_n && (edge_n == done_edge);
        exp_ready = !rst_n || (edge_n >= free_edge - 1);
        for (int p = 0; p < NP; p++) begin
            exp_sel[p*SW +: SW] = SW'(m_sel[p]);
            exp_lock[p] = m_lock[p];
        end
        exp_sync = (pad_hist.size() == S) ? pad_hist[0] : '0;
    end

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_pin = '0; cfg_func = '0; cfg_lock = 1'b0;
        func_o = '1; func_oe = '1; pad_in = '1;
        repeat (3) @(negedge clk);
        n_cmp++; if (sel !== '0) begin n_fail++; $display("FAIL reset_sel: got %h want 0", sel); end
        n_cmp++; if (lock !== '0) begin n_fail++; $display("FAIL reset_lock: got %h want 0", lock); end
        n_cmp++; if (pad_oe !== '0) begin n_fail++; $display("FAIL reset_pad_oe: got %h want 0", pad_oe); end
        n_cmp++; if (pad_out !== '0) begin n_fail++; $display("FAIL reset_pad_o: got %h want 0", pad_out); end
        n_cmp++; if (pad_sync !== '0) begin n_fail++; $display("FAIL reset_sync: got %h want 0", pad_sync); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        n_cmp++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", cfg_done); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", cfg_err); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst_n = 1'b1;
    endtask

    task automatic test_gpio();
        func_oe = '1;
        @(negedge clk);
        n_cmp++; if (pad_oe !== {NP{1'b1}}) begin n_fail++; $display("FAIL gpio_oe_all: got %h want %h", pad_oe, {NP{1'b1}}); end
        for (int i = 0; i < 20; i++) begin
            func_o = {$urandom(), $urandom(), $urandom()};
            func_oe = {$urandom(), $urandom(), $urandom()};
            pad_in = NP'($urandom());
            @(negedge clk);
            n_cmp++; if (pad_out !== exp_pad) begin n_fail++; $display("FAIL gpio_pad_o: got %h want %h", pad_out, exp_pad); end
            n_cmp++; if (pad_oe !== exp_oe) begin n_fail++; $display("FAIL gpio_pad_oe: got %h want %h", pad_oe, exp_oe); end
        end
    endtask

    task automatic test_change();
        func_oe = '1; func_o = {$urandom(), $urandom(), $urandom()};
        cfg_valid = 1'b1; cfg_pin = PW'(5); cfg_func = SW'(2); cfg_lock = 1'b0;
        for (int k = 1; k <= G + 2; k++) begin
            @(negedge clk);
            if (m_acc) cfg_valid = 1'b0;
            if (k <= G) begin
                n_cmp++; if (pad_oe[5] !== 1'b0) begin n_fail++; $display("FAIL change_guard_oe k=%0d: got %b want 0", k, pad_oe[5]); end
            end
            if (k == G + 1) begin
                n_cmp++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL change_done: got %b want 1", cfg_done); end
                n_cmp++; if (pad_out[5] !== func_o[5*NF+2]) begin n_fail++; $display("FAIL change_new_val: got %b want %b", pad_out[5], func_o[5*NF+2]); end
                n_cmp++; if (pad_oe[5] !== 1'b1) begin n_fail++; $display("FAIL change_new_oe: got %b want 1", pad_oe[5]); end
            end
            n_cmp++; if (cfg_done !== exp_done) begin n_fail++; $display("FAIL change_done_model k=%0d: got %b want %b", k, cfg_done, exp_done); end
            n_cmp++; if (sel !== exp_sel) begin n_fail++; $display("FAIL change_sel k=%0d: got %h want %h", k, sel, exp_sel); end
            n_cmp++; if (pad_oe !== exp_oe) begin n_fail++; $display("FAIL change_oe k=%0d: got %h want %h", k, pad_oe, exp_oe); end
        end
    endtask

    task automatic test_lock();
        cfg_valid = 1'b1; cfg_pin = PW'(5); cfg_func = SW'(2); cfg_lock = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (m_acc) cfg_valid = 1'b0;
            if (k == 1) begin
                n_cmp++; if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL lock_done: got %b want 1", cfg_done); end
            end
            n_cmp++; if (lock !== exp_lock) begin n_fail++; $display("FAIL lock_bits k=%0d: got %h want %h", k, lock, exp_lock); end
        end
        n_cmp++; if (lock[5] !== 1'b1) begin n_fail++; $display("FAIL lock_set: got %b want 1", lock[5]); end
        cfg_valid = 1'b1; cfg_func = SW'(0); cfg_lock = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (m_acc) cfg_valid = 1'b0;
            if (k == 1) begin
                n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL locked_err: got %b want 1", cfg_err); end
            end
            n_cmp++; if (cfg_done !== exp_done) begin n_fail++; $display("FAIL locked_done k=%0d: got %b want %b", k, cfg_done, exp_done); end
            n_cmp++; if (cfg_err !== exp_err) begin n_fail++; $display("FAIL locked_err_model k=%0d: got %b want %b", k, cfg_err, exp_err); end
        end
        n_cmp++; if (sel[5*SW +: SW] !== 2'd2) begin n_fail++; $display("FAIL locked_sel: got %0d want 2", sel[5*SW +: SW]); end
    endtask

    task automatic test_bad_pin();
        cfg_valid = 1'b1; cfg_pin = PW'(30); cfg_func = SW'(1); cfg_lock = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0;
        n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL bad_pin_err: got %b want 1", cfg_err); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL bad_pin_ready: got %b want 1", cfg_ready); end
        n_cmp++; if (sel !== exp_sel) begin n_fail++; $display("FAIL bad_pin_sel: got %h want %h", sel, exp_sel); end
        @(negedge clk);
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL bad_pin_pulse: got %b want 0", cfg_err); end
        for (int p = NP; p < 32; p++) begin
            cfg_valid = 1'b1; cfg_pin = PW'(p); cfg_func = SW'($urandom_range(0, NF-1));
            @(negedge clk);
            n_cmp++; if (cfg_err !== exp_err) begin n_fail++; $display("FAIL bad_pin_%0d: got %b want %b", p, cfg_err, exp_err); end
            n_cmp++; if (pad_out !== exp_pad) begin n_fail++; $display("FAIL bad_pin_pad_%0d: got %h want %h", p, pad_out, exp_pad); end
        end
        cfg_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        cfg_valid = 1'b1; cfg_pin = PW'(3); cfg_func = SW'(1); cfg_lock = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin cfg_pin = PW'(7); cfg_func = SW'(1); end
            else if (m_acc) cfg_valid = 1'b0;
            if (cfg_done === 1'b1) dones++;
            if (k <= G + 1) begin
                n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy k=%0d: got %b want 0", k, cfg_ready); end
            end
            n_cmp++; if (cfg_ready !== exp_ready) begin n_fail++; $display("FAIL b2b_ready k=%0d: got %b want %b", k, cfg_ready, exp_ready); end
            n_cmp++; if (cfg_done !== exp_done) begin n_fail++; $display("FAIL b2b_done k=%0d: got %b want %b", k, cfg_done, exp_done); end
        end
        n_cmp++; if (dones !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
        n_cmp++; if (sel[7*SW +: SW] !== 2'd1) begin n_fail++; $display("FAIL b2b_sel7: got %0d want 1", sel[7*SW +: SW]); end
        n_cmp++; if (sel[3*SW +: SW] !== 2'd1) begin n_fail++; $display("FAIL b2b_sel3: got %0d want 1", sel[3*SW +: SW]); end
    endtask

    task automatic test_reset_in_guard();
        func_oe = '1;
        cfg_valid = 1'b1; cfg_pin = PW'(3); cfg_func = SW'(2); cfg_lock = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0;
        n_cmp++; if (cfg_ready !== exp_ready) begin n_fail++; $display("FAIL rig_guard_ready: got %b want %b", cfg_ready, exp_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (sel[3*SW +: SW] !== 2'd0) begin n_fail++; $display("FAIL rig_sel3: got %0d want 0", sel[3*SW +: SW]); end
        n_cmp++; if (pad_oe !== '0) begin n_fail++; $display("FAIL rig_pad_oe: got %h want 0", pad_oe); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rig_ready: got %b want 1", cfg_ready); end
        n_cmp++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL rig_done: got %b want 0", cfg_done); end
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL rig_no_done k=%0d: got %b want 0", k, cfg_done); end
            n_cmp++; if (sel !== exp_sel) begin n_fail++; $display("FAIL rig_sel k=%0d: got %h want %h", k, sel, exp_sel); end
        end
    endtask

    task automatic test_sync();
        int lat = 0;
        pad_in = '0;
        repeat (3) @(negedge clk);
        pad_in[9] = 1'b1;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (pad_sync[9] === 1'b1) lat = i;
        end
        n_cmp++; if (lat !== S) begin n_fail++; $display("FAIL sync_latency: got %0d want %0d", lat, S); end
        for (int i = 0; i < 20; i++) begin
            pad_in = NP'($urandom());
            @(negedge clk);
            n_cmp++; if (pad_sync !== exp_sync) begin n_fail++; $display("FAIL sync_rand: got %h want %h", pad_sync, exp_sync); end
        end
    endtask

    task automatic test_random();
        cfg_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_cmp++; if (cfg_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready i=%0d: got %b want %b", i, cfg_ready, exp_ready); end
            n_cmp++; if (cfg_done !== exp_done) begin n_fail++; $display("FAIL rnd_done i=%0d: got %b want %b", i, cfg_done, exp_done); end
            n_cmp++; if (cfg_err !== exp_err) begin n_fail++; $display("FAIL rnd_err i=%0d: got %b want %b", i, cfg_err, exp_err); end
            n_cmp++; if (sel !== exp_sel) begin n_fail++; $display("FAIL rnd_sel i=%0d: got %h want %h", i, sel, exp_sel); end
            n_cmp++; if (lock !== exp_lock) begin n_fail++; $display("FAIL rnd_lock i=%0d: got %h want %h", i, lock, exp_lock); end
            n_cmp++; if (pad_out !== exp_pad) begin n_fail++; $display("FAIL rnd_pad_o i=%0d: got %h want %h", i, pad_out, exp_pad); end
            n_cmp++; if (pad_oe !== exp_oe) begin n_fail++; $display("FAIL rnd_pad_oe i=%0d: got %h want %h", i, pad_oe, exp_oe); end
            n_cmp++; if (pad_sync !== exp_sync) begin n_fail++; $display("FAIL rnd_sync i=%0d: got %h want %h", i, pad_sync, exp_sync); end
            if (m_acc || !cfg_valid) begin
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_pin   = PW'($urandom_range(0, 27));
                cfg_func  = SW'($urandom_range(0, NF-1));
                cfg_lock  = ($urandom_range(0, 19) == 0);
            end
            func_o  = {$urandom(), $urandom(), $urandom()};
            func_oe = {$urandom(), $urandom(), $urandom()};
            pad_in  = NP'($urandom());
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_gpio();
        test_change();
        test_lock();
        test_bad_pin();
        test_back_to_back();
        test_reset_in_guard();
        test_sync();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
